// File: rtl/param_iface.sv
`default_nettype none
// ============================================================================
//  Module      : param_iface
//  Description : Width-parameterized two-entry skid buffer for a valid/ready
//                channel. Accepts one word per cycle, presents it one cycle
//                later on registered outputs, sustains full throughput and
//                never drops, duplicates or reorders words under backpressure.
//                in_ready is driven purely from flops, so there is no
//                combinational path from out_ready to in_ready.
//  Options     : `define PARAM_IFACE_PARITY_EN adds in_parity, out_parity and
//                a sticky parity_err flag (even parity, checked on accept).
//  Revision    : 1.0  initial release
// ============================================================================
module param_iface #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PARAM_IFACE_PARITY_EN
    ,
    input  logic             in_parity,
    output logic             out_parity,
    output logic             parity_err
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;

    logic             w_accept;
    logic             w_consume;
    logic             w_load_main_in;
    logic             w_load_skid_in;
    logic             w_move_skid;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    // Next-state and datapath load-select decode from the handshake events
    always_comb begin
        w_state_nxt    = r_state;
        w_load_main_in = 1'b0;
        w_load_skid_in = 1'b0;
        w_move_skid    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    // Main drains and refills in the same cycle
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt    = ST_FULL;
                    w_load_skid_in = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a consume can occur
                if (w_consume) begin
                    w_state_nxt = ST_ONE;
                    w_move_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register with handshake outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    // Main/skid payload registers; in_data is only sampled on an accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_move_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid_in) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

`ifdef PARAM_IFACE_PARITY_EN
    logic r_main_par;
    logic r_skid_par;
    logic r_parity_err;

    // Parity bit travels with its word; error flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_par   <= 1'b0;
            r_skid_par   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_load_main_in) begin
                r_main_par <= in_parity;
            end else if (w_move_skid) begin
                r_main_par <= r_skid_par;
            end
            if (w_load_skid_in) begin
                r_skid_par <= in_parity;
            end
            if (w_accept && ((^in_data) != in_parity)) begin
                r_parity_err <= 1'b1;
            end
        end
    end

    assign out_parity = r_main_par;
    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_iface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_iface
//  Description : Self-checking bench for param_iface. Three widths (16, 4, 8);
//                the 8-bit instance is tracked by a capacity-2 FIFO model.
//                Build with PARAM_IFACE_PARITY_EN to add the parity test.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_iface;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [15:0] d16 = '0;
    logic        v16 = 1'b0;
    logic        r16 = 1'b0;
    logic        ir16;
    logic [15:0] od16;
    logic        ov16;

    logic [3:0]  d4 = '0;
    logic        v4 = 1'b0;
    logic        r4 = 1'b0;
    logic        ir4;
    logic [3:0]  od4;
    logic        ov4;

    logic [7:0]  d8 = '0;
    logic        v8 = 1'b0;
    logic        r8 = 1'b0;
    logic        ir8;
    logic [7:0]  od8;
    logic        ov8;

`ifdef PARAM_IFACE_PARITY_EN
    logic        ip16 = 1'b0, op16, pe16;
    logic        ip4  = 1'b0, op4,  pe4;
    logic        ip8  = 1'b0, op8,  pe8;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model for the 8-bit instance: ordered store of at most 2 words
    logic [7:0] q[$];
    logic       last_con;
    logic [7:0] last_word;

    always #5 clk = ~clk;

    param_iface #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_data(d16), .in_valid(v16), .in_ready(ir16),
        .out_data(od16), .out_valid(ov16), .out_ready(r16)
`ifdef PARAM_IFACE_PARITY_EN
        , .in_parity(ip16), .out_parity(op16), .parity_err(pe16)
`endif
    );

    param_iface #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_valid(v4), .in_ready(ir4),
        .out_data(od4), .out_valid(ov4), .out_ready(r4)
`ifdef PARAM_IFACE_PARITY_EN
        , .in_parity(ip4), .out_parity(op4), .parity_err(pe4)
`endif
    );

    param_iface u8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_ready(ir8),
        .out_data(od8), .out_valid(ov8), .out_ready(r8)
`ifdef PARAM_IFACE_PARITY_EN
        , .in_parity(ip8), .out_parity(op8), .parity_err(pe8)
`endif
    );

    // Advance one clock and update the FIFO model from the inputs seen at the edge
    task automatic step();
        logic       acc;
        logic       con;
        logic [7:0] d;
        acc = v8 && (q.size() < 2);
        con = r8 && (q.size() > 0);
        d   = d8;
        last_con  = con;
        last_word = (q.size() > 0) ? q[0] : 8'h00;
        @(posedge clk);
        #1;
        if (con) void'(q.pop_front());
        if (acc) q.push_back(d);
    endtask

    task automatic do_reset();
        v16 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        r16 = 1'b0; r4 = 1'b0; r8 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ov16 !== 1'b0 || od16 !== 16'h0 || ir16 !== 1'b1) begin
            failures++;
            $display("FAIL reset_w16 valid=%b data=%h ready=%b expected 0/0000/1", ov16, od16, ir16);
        end
        checks++;
        if (ov4 !== 1'b0 || od4 !== 4'h0 || ir4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_w4 valid=%b data=%h ready=%b expected 0/0/1", ov4, od4, ir4);
        end
        checks++;
        if (ov8 !== 1'b0 || od8 !== 8'h0 || ir8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_w8 valid=%b data=%h ready=%b expected 0/00/1", ov8, od8, ir8);
        end
    endtask

    task automatic test_widths();
        do_reset();
        d16 = 16'hABCD; v16 = 1'b1;
        d4  = 4'hF;     v4  = 1'b1;
        d8  = 8'h55;    v8  = 1'b1;
        step();
        v16 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        d16 = 16'h1234; d4 = 4'h3; d8 = 8'hAA;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (ov16 !== 1'b1 || od16 !== 16'hABCD) begin
                failures++;
                $display("FAIL width16_hold cyc=%0d valid=%b data=%h expected 1/abcd", i, ov16, od16);
            end
            checks++;
            if (ov4 !== 1'b1 || od4 !== 4'hF) begin
                failures++;
                $display("FAIL width4_hold cyc=%0d valid=%b data=%h expected 1/f", i, ov4, od4);
            end
            checks++;
            if (ov8 !== 1'b1 || od8 !== 8'h55) begin
                failures++;
                $display("FAIL width8_hold cyc=%0d valid=%b data=%h expected 1/55", i, ov8, od8);
            end
            if (i < 10) step();
        end
    endtask

    task automatic test_stream();
        do_reset();
        r8 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d8 = 8'(i);
            v8 = 1'b1;
            step();
            checks++;
            if (ov8 !== 1'b1 || od8 !== 8'(i) || ir8 !== 1'b1) begin
                failures++;
                $display("FAIL stream word=%0d valid=%b data=%h ready=%b expected 1/%h/1",
                         i, ov8, od8, ir8, 8'(i));
            end
        end
        v8 = 1'b0;
        step();
        checks++;
        if (ov8 !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain valid=%b expected 0", ov8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_words[3];
        logic [7:0] got[$];
        exp_words[0] = 8'h11; exp_words[1] = 8'h22; exp_words[2] = 8'h33;
        do_reset();
        r8 = 1'b0;
        v8 = 1'b1; d8 = 8'h11;
        step();
        checks++;
        if (ir8 !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_after_first ready=%b expected 1", ir8);
        end
        d8 = 8'h22;
        step();
        checks++;
        if (ir8 !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_after_second ready=%b expected 0", ir8);
        end
        d8 = 8'h33;
        step();
        checks++;
        if (ir8 !== 1'b0 || od8 !== 8'h11) begin
            failures++;
            $display("FAIL bp_stall ready=%b data=%h expected 0/11", ir8, od8);
        end
        r8 = 1'b1;
        for (int c = 0; c < 8 && got.size() < 3; c++) begin
            if (q.size() == 2 && c > 0) v8 = 1'b0;
            if (got.size() >= 2) v8 = 1'b0;
            if (ov8 && r8) got.push_back(od8);
            step();
        end
        v8 = 1'b0;
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL bp_count got=%0d expected 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k] !== exp_words[k]) begin
                    failures++;
                    $display("FAIL bp_order idx=%0d got=%h expected %h", k, got[k], exp_words[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        int         accepted = 0;
        int         cycles   = 0;
        int         errs     = 0;
        logic [7:0] prev_data;
        logic       stalled;
        do_reset();
        stalled = 1'b0;
        prev_data = 8'h00;
        while (accepted < 10000 && cycles < 60000) begin
            v8 = ($urandom_range(0, 9) < 7);
            r8 = ($urandom_range(0, 9) < 6);
            d8 = v8 ? 8'($urandom) : 8'hxx;
            if (v8 && q.size() < 2) accepted++;
            stalled   = ov8 && !r8;
            prev_data = od8;
            step();
            cycles++;
            checks++;
            if (ov8 !== (q.size() > 0) || ir8 !== (q.size() < 2) ||
                (q.size() > 0 && od8 !== q[0])) begin
                failures++;
                errs++;
                if (errs < 10)
                    $display("FAIL random cyc=%0d valid=%b ready=%b data=%h expected %b/%b/%h",
                             cycles, ov8, ir8, od8, q.size() > 0, q.size() < 2,
                             (q.size() > 0) ? q[0] : 8'h00);
            end
            if (stalled) begin
                checks++;
                if (od8 !== prev_data) begin
                    failures++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL stall_stable cyc=%0d data=%h expected %h", cycles, od8, prev_data);
                end
            end
        end
        checks++;
        if (accepted < 10000) begin
            failures++;
            $display("FAIL random_budget accepted=%0d expected 10000", accepted);
        end
        v8 = 1'b0;
        r8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (last_con && ov8 !== (q.size() > 0)) begin
                failures++;
                $display("FAIL random_drain valid=%b expected %b", ov8, q.size() > 0);
            end
        end
        checks++;
        if (ov8 !== 1'b0) begin
            failures++;
            $display("FAIL random_empty valid=%b expected 0", ov8);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        r8 = 1'b0;
        v8 = 1'b1; d8 = 8'hA1;
        step();
        d8 = 8'hB2;
        step();
        checks++;
        if (ir8 !== 1'b0 || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_full ready=%b valid=%b expected 0/1", ir8, ov8);
        end
        // Reset coincides with an offered word and a consume attempt
        v8 = 1'b1; d8 = 8'hC3; r8 = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        v8 = 1'b0;
        checks++;
        if (ov8 !== 1'b0 || od8 !== 8'h00 || ir8 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_after valid=%b data=%h ready=%b expected 0/00/1", ov8, od8, ir8);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (ov8 !== 1'b0) begin
                failures++;
                $display("FAIL midrst_no_emit cyc=%0d valid=%b data=%h expected 0", i, ov8, od8);
            end
        end
    endtask

`ifdef PARAM_IFACE_PARITY_EN
    task automatic test_parity();
        do_reset();
        r8 = 1'b0;
        v8 = 1'b1; d8 = 8'h03; ip8 = 1'b0;
        step();
        v8 = 1'b0;
        checks++;
        if (pe8 !== 1'b0 || op8 !== 1'b0) begin
            failures++;
            $display("FAIL parity_good err=%b par=%b expected 0/0", pe8, op8);
        end
        do_reset();
        v8 = 1'b1; d8 = 8'h55; ip8 = 1'b1;
        step();
        v8 = 1'b0; ip8 = 1'b0;
        checks++;
        if (pe8 !== 1'b1 || ov8 !== 1'b1 || od8 !== 8'h55 || op8 !== 1'b1) begin
            failures++;
            $display("FAIL parity_bad err=%b valid=%b data=%h par=%b expected 1/1/55/1",
                     pe8, ov8, od8, op8);
        end
        r8 = 1'b1;
        v8 = 1'b1; d8 = 8'h01; ip8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pe8 !== 1'b1) begin
                failures++;
                $display("FAIL parity_sticky cyc=%0d err=%b expected 1", i, pe8);
            end
        end
        do_reset();
        checks++;
        if (pe8 !== 1'b0) begin
            failures++;
            $display("FAIL parity_reset err=%b expected 0", pe8);
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_widths();
        test_stream();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef PARAM_IFACE_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
